// File: rtl/load_store_unit_if.sv
// Bundle of the load/store unit's request, RAM and regfile-write-port signals.
// Latency: none (wires only).
// Backpressure: none. While busy is high, the unit ignores req.
// Ports (slave = unit side):
//   request in : req, is_load, is_byte, addr, st_data, rd_addr
//   RAM         : ram_addr/ram_w_en/ram_w_data out, ram_rd_data in
//   regfile out : w_data3, w_addr3, w_en3
//   status out  : busy, done, err
interface load_store_unit_if #(
    parameter int ADDR_W = 11
);
    logic              req;
    logic              is_load;
    logic              is_byte;
    logic [31:0]       addr;
    logic [31:0]       st_data;
    logic [3:0]        rd_addr;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_w_en;
    logic [31:0]       ram_w_data;
    logic [31:0]       ram_rd_data;
    logic [31:0]       w_data3;
    logic [3:0]        w_addr3;
    logic              w_en3;
    logic              busy;
    logic              done;
    logic              err;

    // The load/store unit itself.
    modport slave (
        input  req, is_load, is_byte, addr, st_data, rd_addr, ram_rd_data,
        output ram_addr, ram_w_en, ram_w_data, w_data3, w_addr3, w_en3,
        output busy, done, err
    );

    // The datapath/RAM side that drives requests and read data.
    modport master (
        output req, is_load, is_byte, addr, st_data, rd_addr, ram_rd_data,
        input  ram_addr, ram_w_en, ram_w_data, w_data3, w_addr3, w_en3,
        input  busy, done, err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer between the CPU datapath and a word-wide single-port RAM.
// Latency from the accepting edge to done: fault 1, STR 2, LDR/LDRB RD_LAT+2, STRB RD_LAT+3.
// Backpressure: one access at a time. req is sampled only in IDLE, and a req while busy is dropped.
// Ports: clk, rst (sync, active high); io_bus (slave modport) carries the request,
//        the RAM port, regfile write port 3 and the busy/done/err status.
module load_store_unit #(
    parameter int ADDR_W = 11,
    parameter int RD_LAT = 1     // 1..7
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   io_bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_is_load;
    logic              r_is_byte;
    logic              r_fault;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_idx;
    logic [31:0]       r_st_data;
    logic [31:0]       r_word;
    logic [3:0]        r_rd_addr;
    logic [2:0]        r_cnt;

    logic              w_accept;
    logic              w_fault;
    logic [31:0]       w_merged;
    logic [7:0]        w_lane_byte;

    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_w_en;
    logic [31:0]       w_ram_w_data;
    logic [31:0]       w_w_data3;
    logic [3:0]        w_w_addr3;
    logic              w_w_en3;
    logic              w_busy;
    logic              w_done;
    logic              w_err;

    assign w_accept = (r_state == S_IDLE) && io_bus.req;

    // Out of range: any address bit above the RAM's byte range is set.
    // A word access must also be 4-byte aligned.
    assign w_fault = ((io_bus.addr >> (ADDR_W + 2)) != 32'd0) ||
                     (!io_bus.is_byte && (io_bus.addr[1:0] != 2'b00));

    // Little-endian lane select: lane n is bits [8n+7:8n].
    always_comb begin
        w_merged = r_word;
        w_merged[{r_lane, 3'b000} +: 8] = r_st_data[7:0];
        w_lane_byte = r_word[{r_lane, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ram_addr   = '0;
        w_ram_w_en   = 1'b0;
        w_ram_w_data = 32'd0;
        w_w_data3    = 32'd0;
        w_w_addr3    = 4'd0;
        w_w_en3      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (io_bus.req) begin
                    if (w_fault) begin
                        w_next = S_DONE;
                    end else if (io_bus.is_load || io_bus.is_byte) begin
                        w_next = S_READ;
                    end else begin
                        w_next = S_WRITE;
                    end
                end
            end
            S_READ: begin
                w_ram_addr = r_idx;
                if (r_cnt == 3'd0) begin
                    w_next = S_CAPT;
                end
            end
            S_CAPT: begin
                w_ram_addr = r_idx;
                w_next     = r_is_load ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                w_ram_addr   = r_idx;
                w_ram_w_en   = 1'b1;
                w_ram_w_data = r_is_byte ? w_merged : r_st_data;
                w_next       = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_err  = r_fault;
                if (r_is_load && !r_fault) begin
                    w_w_en3   = 1'b1;
                    w_w_addr3 = r_rd_addr;
                    w_w_data3 = r_is_byte ? {24'd0, w_lane_byte} : r_word;
                end
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        w_busy = (r_state != S_IDLE);

        // Reset must take effect in the cycle it is asserted, so that an
        // in-flight write strobe or regfile write is squashed immediately.
        if (rst) begin
            w_ram_addr   = '0;
            w_ram_w_en   = 1'b0;
            w_ram_w_data = 32'd0;
            w_w_data3    = 32'd0;
            w_w_addr3    = 4'd0;
            w_w_en3      = 1'b0;
            w_busy       = 1'b0;
            w_done       = 1'b0;
            w_err        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load <= 1'b0;
            r_is_byte <= 1'b0;
            r_fault   <= 1'b0;
            r_lane    <= 2'd0;
            r_idx     <= '0;
            r_st_data <= 32'd0;
            r_word    <= 32'd0;
            r_rd_addr <= 4'd0;
            r_cnt     <= 3'd0;
        end else begin
            if (w_accept) begin
                r_is_load <= io_bus.is_load;
                r_is_byte <= io_bus.is_byte;
                r_fault   <= w_fault;
                r_lane    <= io_bus.addr[1:0];
                r_idx     <= io_bus.addr[ADDR_W+1:2];
                r_st_data <= io_bus.st_data;
                r_rd_addr <= io_bus.rd_addr;
                // READ lasts RD_LAT cycles: it leaves when the counter hits zero.
                r_cnt     <= 3'(RD_LAT - 1);
            end
            if (r_state == S_READ && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (r_state == S_CAPT) begin
                r_word <= io_bus.ram_rd_data;
            end
        end
    end

    assign io_bus.ram_addr   = w_ram_addr;
    assign io_bus.ram_w_en   = w_ram_w_en;
    assign io_bus.ram_w_data = w_ram_w_data;
    assign io_bus.w_data3    = w_w_data3;
    assign io_bus.w_addr3    = w_w_addr3;
    assign io_bus.w_en3      = w_w_en3;
    assign io_bus.busy       = w_busy;
    assign io_bus.done       = w_done;
    assign io_bus.err        = w_err;
endmodule
